// File: rtl/kws_serial_host.sv
// kws_serial_host: host-side driver for the kws_v3 serial accelerator port.
// Shifts parallel words out MSB-first under acc_load_enable, pulses acc_start
// after the last word of a frame, then collects RESULT_W serial result bits
// once acc_done rises. A sticky timeout flag covers a silent accelerator.
//
// Handshake rule (both sides): a word moves on a clock edge where
// in_valid & in_ready are both 1; a result moves on an edge where
// res_valid & res_ready are both 1. in_ready and res_valid are registered and
// never depend combinationally on in_valid or res_ready.
module kws_serial_host #(
    parameter int DATA_W         = 8,
    parameter int RESULT_W       = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic                acc_serial_data,
    output logic                acc_load_enable,
    output logic                acc_start,
    input  logic                acc_serial_result,
    input  logic                acc_done,
    output logic [RESULT_W-1:0] res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          dbg_state
);

    localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int RES_CW = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
    localparam int TMO_CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(DATA_W - 1);
    localparam logic [RES_CW-1:0] RES_LAST  = RES_CW'(RESULT_W - 1);
    localparam logic [TMO_CW-1:0] TMO_LIMIT = TMO_CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT     = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;      // bits still to be presented
    logic                last_q, last_d;        // word being shifted ends the frame
    logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;  // index of the bit currently on the wire
    logic [TMO_CW-1:0]   tmo_cnt_q, tmo_cnt_d;  // WAIT_DONE cycles elapsed without acc_done
    logic [RES_CW-1:0]   res_cnt_q, res_cnt_d;  // index of the last result bit sampled
    logic [RESULT_W-1:0] cap_q, cap_d;          // partial result, kept apart from res_data
    logic [RESULT_W-1:0] cap_shift;

    logic                in_ready_q, in_ready_d;
    logic                ser_data_q, ser_data_d;
    logic                load_en_q, load_en_d;
    logic                start_q, start_d;
    logic [RESULT_W-1:0] res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                tmo_err_q, tmo_err_d;

    logic                accept;
    logic                load_word;

    assign accept    = in_valid & in_ready_q;
    assign cap_shift = (cap_q << 1) | RESULT_W'(acc_serial_result);

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        res_cnt_d   = res_cnt_q;
        cap_d       = cap_q;
        in_ready_d  = in_ready_q;
        ser_data_d  = ser_data_q;
        load_en_d   = load_en_q;
        start_d     = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        tmo_err_d   = tmo_err_q;
        load_word   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    load_word = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q != BIT_LAST) begin
                    ser_data_d = shift_q[DATA_W-1];
                    shift_d    = shift_q << 1;
                    bit_cnt_d  = bit_cnt_q + BIT_CW'(1);
                    // Open the input for the final bit so a follow-on word
                    // can be taken without a load_enable gap.
                    in_ready_d = ((bit_cnt_q + BIT_CW'(1)) == BIT_LAST) && !last_q;
                end else if (accept) begin
                    load_word = 1'b1;
                end else begin
                    load_en_d  = 1'b0;
                    ser_data_d = 1'b0;
                    if (last_q) begin
                        state_d    = S_START;
                        start_d    = 1'b1;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d    = S_IDLE;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d   = S_WAIT_DONE;
                tmo_cnt_d = '0;
            end
            S_WAIT_DONE: begin
                if (acc_done) begin
                    // First result bit is the MSB.
                    cap_d     = RESULT_W'(acc_serial_result);
                    res_cnt_d = '0;
                    if (RESULT_W == 1) begin
                        res_data_d  = RESULT_W'(acc_serial_result);
                        res_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if ((tmo_cnt_q + TMO_CW'(1)) == TMO_LIMIT) begin
                        tmo_err_d  = 1'b1;
                        state_d    = S_IDLE;
                        in_ready_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_CW'(1);
                    end
                end
            end
            S_CAPTURE: begin
                // acc_done is not looked at here: once started, the capture
                // always runs to RESULT_W samples.
                if ((res_cnt_q + RES_CW'(1)) == RES_LAST) begin
                    res_data_d  = cap_shift;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cap_d     = cap_shift;
                    res_cnt_d = res_cnt_q + RES_CW'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
        endcase

        // Taking a word (from IDLE or on the final SHIFT bit) puts its MSB on
        // the wire next cycle and clears any earlier timeout.
        if (load_word) begin
            ser_data_d = in_data[DATA_W-1];
            shift_d    = in_data << 1;
            last_d     = in_last;
            bit_cnt_d  = '0;
            load_en_d  = 1'b1;
            tmo_err_d  = 1'b0;
            state_d    = S_SHIFT;
            in_ready_d = (DATA_W == 1) && !in_last;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            last_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            res_cnt_q   <= '0;
            cap_q       <= '0;
            in_ready_q  <= 1'b0;
            ser_data_q  <= 1'b0;
            load_en_q   <= 1'b0;
            start_q     <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            res_cnt_q   <= res_cnt_d;
            cap_q       <= cap_d;
            in_ready_q  <= in_ready_d;
            ser_data_q  <= ser_data_d;
            load_en_q   <= load_en_d;
            start_q     <= start_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign acc_serial_data = ser_data_q;
    assign acc_load_enable = load_en_q;
    assign acc_start       = start_q;
    assign res_data        = res_data_q;
    assign res_valid       = res_valid_q;
    assign busy            = busy_q;
    assign timeout_err     = tmo_err_q;
    assign dbg_state       = state_q;

endmodule
